// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//
// Write-back front end for a 3-read/2-write register file. Three producers share the two write
// ports:
//   - ALU results pass straight through to port A.
//   - Post-increment (pinc) address updates and buffered LSU load data share port B. Pinc always
//     wins that port.
//   - Loads wait in a small FIFO until port B is free.
//
// Write-after-write order is kept by per-entry kill bits. ALU and pinc writes are always younger
// than any buffered or arriving load. A matching younger write therefore kills the load, and the
// load is later popped without being written. A pending bitmap shows the decoder which registers
// still have a live load outstanding.
//
// Optional feature (define RF_ZERO_REG_EN):
//   - Address 0 is a hard zero register.
//   - All writes to it are suppressed.
//   - Loads to it are accepted but not enqueued.
//   - pending_o[0] is tied low.
//
// Ports:
//   clk, rst_n                       clock (rising edge), asynchronous active-low reset
//   alu_we_i/alu_waddr_i/alu_wdata_i ALU write request
//   pinc_we_i/pinc_waddr_i/...       post-increment write request (port B priority)
//   lsu_valid_i/lsu_ready_o/...      load data handshake into the load FIFO
//   flush_i                          discard all buffered loads and any arriving load
//   we_a_o/waddr_a_o/wdata_a_o       register file write port A
//   we_b_o/waddr_b_o/wdata_b_o       register file write port B
//   pending_o                        bit r set while a live buffered load targets r
//   fifo_empty_o                     no entries buffered (killed entries still count)

module regfile_wb_arbiter #(
   parameter int unsigned ADDR_WIDTH = 5,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,

   input  logic                     alu_we_i,
   input  logic [ADDR_WIDTH-1:0]    alu_waddr_i,
   input  logic [DATA_WIDTH-1:0]    alu_wdata_i,

   input  logic                     pinc_we_i,
   input  logic [ADDR_WIDTH-1:0]    pinc_waddr_i,
   input  logic [DATA_WIDTH-1:0]    pinc_wdata_i,

   input  logic                     lsu_valid_i,
   output logic                     lsu_ready_o,
   input  logic [ADDR_WIDTH-1:0]    lsu_waddr_i,
   input  logic [DATA_WIDTH-1:0]    lsu_wdata_i,

   input  logic                     flush_i,

   output logic                     we_a_o,
   output logic [ADDR_WIDTH-1:0]    waddr_a_o,
   output logic [DATA_WIDTH-1:0]    wdata_a_o,

   output logic                     we_b_o,
   output logic [ADDR_WIDTH-1:0]    waddr_b_o,
   output logic [DATA_WIDTH-1:0]    wdata_b_o,

   output logic [2**ADDR_WIDTH-1:0] pending_o,
   output logic                     fifo_empty_o
);

   localparam int unsigned NUM_WORDS = 2 ** ADDR_WIDTH;
   localparam int unsigned PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W     = PTR_W + 1;

   // ---------------------------------------------------------------------------------------------
   // Load FIFO state
   // ---------------------------------------------------------------------------------------------
   logic [ADDR_WIDTH-1:0] addr_q [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] data_q [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] valid_q, valid_d;
   logic [FIFO_DEPTH-1:0] kill_q, kill_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;

   logic [FIFO_DEPTH-1:0] entry_hit;
   logic                  lsu_hit;
   logic                  lsu_keep;
   logic                  head_valid;
   logic                  head_dead;
   logic                  head_write;
   logic                  pop;
   logic                  push;
   logic                  we_b_sel;

   // ---------------------------------------------------------------------------------------------
   // Kill detection
   // ---------------------------------------------------------------------------------------------
   // A same-cycle ALU or pinc write to an entry's register makes that entry stale.
   always_comb begin
      entry_hit = '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         entry_hit[i] = (alu_we_i  && (addr_q[i] == alu_waddr_i)) ||
                        (pinc_we_i && (addr_q[i] == pinc_waddr_i));
      end
   end

   assign lsu_hit = (alu_we_i  && (lsu_waddr_i == alu_waddr_i)) ||
                    (pinc_we_i && (lsu_waddr_i == pinc_waddr_i));

`ifdef RF_ZERO_REG_EN
   assign lsu_keep = (lsu_waddr_i != '0);
`else
   assign lsu_keep = 1'b1;
`endif

   // ---------------------------------------------------------------------------------------------
   // Head handling and handshake
   // ---------------------------------------------------------------------------------------------
   assign head_valid = valid_q[rd_ptr_q];

   // The head counts as dead even when the kill arrives this cycle. Port B outranks port A inside
   // the register file, so letting the head write here would overwrite the younger ALU value.
   assign head_dead  = kill_q[rd_ptr_q] | entry_hit[rd_ptr_q];
   assign head_write = head_valid && !head_dead && !pinc_we_i && !flush_i;

   // A dead head is retired even while pinc owns port B, since retiring it needs no write port.
   assign pop        = head_valid && (head_dead || !pinc_we_i);

   // Ready depends on registered state only. This keeps pinc and pop off the LSU timing path.
   assign lsu_ready_o  = (count_q < CNT_W'(FIFO_DEPTH));
   assign push         = lsu_valid_i && lsu_ready_o && !flush_i && lsu_keep;
   assign fifo_empty_o = (count_q == '0);

   // ---------------------------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------------------------
   always_comb begin
      valid_d  = valid_q;
      kill_d   = kill_q | (valid_q & entry_hit);
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;

      if (flush_i) begin
         valid_d  = '0;
         kill_d   = '0;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (pop) begin
            valid_d[rd_ptr_q] = 1'b0;
            kill_d[rd_ptr_q]  = 1'b0;
            rd_ptr_d          = rd_ptr_q + PTR_W'(1);
         end
         // The push slot never aliases the pop slot: that would need a full FIFO, and ready
         // blocks pushes into a full FIFO.
         if (push) begin
            valid_d[wr_ptr_q] = 1'b1;
            kill_d[wr_ptr_q]  = lsu_hit;
            wr_ptr_d          = wr_ptr_q + PTR_W'(1);
         end
         unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q  <= '0;
         kill_q   <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         valid_q  <= valid_d;
         kill_q   <= kill_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Payload storage needs no reset: valid_q gates every use of it.
   always_ff @(posedge clk) begin
      if (push) begin
         addr_q[wr_ptr_q] <= lsu_waddr_i;
         data_q[wr_ptr_q] <= lsu_wdata_i;
      end
   end

   // ---------------------------------------------------------------------------------------------
   // Write ports
   // ---------------------------------------------------------------------------------------------
   assign waddr_a_o = alu_waddr_i;
   assign wdata_a_o = alu_wdata_i;

   always_comb begin
      we_b_sel  = 1'b0;
      waddr_b_o = pinc_waddr_i;
      wdata_b_o = pinc_wdata_i;
      if (pinc_we_i) begin
         we_b_sel = 1'b1;
      end else if (head_write) begin
         we_b_sel  = 1'b1;
         waddr_b_o = addr_q[rd_ptr_q];
         wdata_b_o = data_q[rd_ptr_q];
      end
   end

`ifdef RF_ZERO_REG_EN
   assign we_a_o = alu_we_i && (alu_waddr_i != '0);
   assign we_b_o = we_b_sel && (waddr_b_o != '0);
`else
   assign we_a_o = alu_we_i;
   assign we_b_o = we_b_sel;
`endif

   // ---------------------------------------------------------------------------------------------
   // Pending bitmap
   // ---------------------------------------------------------------------------------------------
   // Built from registered state only, so a kill shows up here one cycle after it happens.
   always_comb begin
      pending_o = '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         if (valid_q[i] && !kill_q[i]) begin
            pending_o[addr_q[i]] = 1'b1;
         end
      end
`ifdef RF_ZERO_REG_EN
      pending_o[0] = 1'b0;
`endif
   end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter.
//
// Directed scenarios compare against fixed expected values. The random scenario compares every
// cycle against a queue-based model of the buffered loads.
module tb_regfile_wb_arbiter;

   localparam int AW    = 5;
   localparam int DW    = 32;
   localparam int DEPTH = 4;
`ifdef RF_ZERO_REG_EN
   localparam bit ZERO = 1'b1;
`else
   localparam bit ZERO = 1'b0;
`endif

   logic clk, rst_n;
   logic alu_we_i, pinc_we_i, lsu_valid_i, flush_i;
   logic [AW-1:0] alu_waddr_i, pinc_waddr_i, lsu_waddr_i;
   logic [DW-1:0] alu_wdata_i, pinc_wdata_i, lsu_wdata_i;
   logic lsu_ready_o, we_a_o, we_b_o, fifo_empty_o;
   logic [AW-1:0] waddr_a_o, waddr_b_o;
   logic [DW-1:0] wdata_a_o, wdata_b_o;
   logic [2**AW-1:0] pending_o;

   int checks = 0;
   int errors = 0;

   regfile_wb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .alu_we_i(alu_we_i), .alu_waddr_i(alu_waddr_i), .alu_wdata_i(alu_wdata_i),
      .pinc_we_i(pinc_we_i), .pinc_waddr_i(pinc_waddr_i), .pinc_wdata_i(pinc_wdata_i),
      .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o), .lsu_waddr_i(lsu_waddr_i),
      .lsu_wdata_i(lsu_wdata_i), .flush_i(flush_i),
      .we_a_o(we_a_o), .waddr_a_o(waddr_a_o), .wdata_a_o(wdata_a_o),
      .we_b_o(we_b_o), .waddr_b_o(waddr_b_o), .wdata_b_o(wdata_b_o),
      .pending_o(pending_o), .fifo_empty_o(fifo_empty_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ----------------------------------------------------------------------------------------------
   // Reference model: the list of buffered loads, oldest first
   // ----------------------------------------------------------------------------------------------
   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      bit            killed;
   } ent_t;

   ent_t mq[$];
   logic [DW-1:0] rf [2**AW];

   logic             exp_we_a, exp_we_b, exp_ready, exp_empty;
   logic [AW-1:0]    exp_waddr_b;
   logic [DW-1:0]    exp_wdata_b;
   logic [2**AW-1:0] exp_pending;

   // True when a younger ALU or pinc write this cycle targets register a.
   function automatic bit younger_write(input logic [AW-1:0] a);
      return (alu_we_i && a == alu_waddr_i) || (pinc_we_i && a == pinc_waddr_i);
   endfunction

   task automatic calc_exp();
      exp_we_a    = alu_we_i && !(ZERO && alu_waddr_i == '0);
      exp_ready   = (mq.size() < DEPTH);
      exp_empty   = (mq.size() == 0);
      exp_pending = '0;
      foreach (mq[k]) if (!mq[k].killed) exp_pending[mq[k].addr] = 1'b1;
      if (ZERO) exp_pending[0] = 1'b0;
      exp_we_b    = 1'b0;
      exp_waddr_b = '0;
      exp_wdata_b = '0;
      if (pinc_we_i) begin
         exp_we_b    = !(ZERO && pinc_waddr_i == '0);
         exp_waddr_b = pinc_waddr_i;
         exp_wdata_b = pinc_wdata_i;
      end else if (mq.size() > 0 && !flush_i && !mq[0].killed && !younger_write(mq[0].addr)) begin
         exp_we_b    = 1'b1;
         exp_waddr_b = mq[0].addr;
         exp_wdata_b = mq[0].data;
      end
   endtask

   task automatic model_edge();
      bit room;
      if (!rst_n || flush_i) begin
         mq.delete();
         return;
      end
      room = (mq.size() < DEPTH);
      if (mq.size() > 0 && (mq[0].killed || younger_write(mq[0].addr) || !pinc_we_i))
         void'(mq.pop_front());
      foreach (mq[k]) if (younger_write(mq[k].addr)) mq[k].killed = 1'b1;
      if (lsu_valid_i && room && !(ZERO && lsu_waddr_i == '0))
         mq.push_back('{addr: lsu_waddr_i, data: lsu_wdata_i, killed: younger_write(lsu_waddr_i)});
   endtask

   task automatic to_neg();
      @(negedge clk);
      calc_exp();
   endtask

   // Commit this cycle's port writes to a register-file image. Port B is applied last, so it wins.
   task automatic to_edge();
      if (we_a_o) rf[waddr_a_o] = wdata_a_o;
      if (we_b_o) rf[waddr_b_o] = wdata_b_o;
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic idle_inputs();
      alu_we_i = 0;  alu_waddr_i = '0;  alu_wdata_i = '0;
      pinc_we_i = 0; pinc_waddr_i = '0; pinc_wdata_i = '0;
      lsu_valid_i = 0; lsu_waddr_i = '0; lsu_wdata_i = '0;
      flush_i = 0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      mq.delete();
      idle_inputs();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic push_load(input logic [AW-1:0] a, input logic [DW-1:0] d);
      lsu_valid_i = 1; lsu_waddr_i = a; lsu_wdata_i = d;
   endtask

   // ----------------------------------------------------------------------------------------------
   // Scenarios
   // ----------------------------------------------------------------------------------------------
   task automatic test_reset();
      rst_n = 1'b0;
      idle_inputs();
      pinc_we_i = 1; pinc_waddr_i = 5'd7; alu_we_i = 1; alu_waddr_i = 5'd2; alu_wdata_i = 32'h1234;
      #7;
      checks++; if (lsu_ready_o !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", lsu_ready_o); end
      checks++; if (pending_o !== '0) begin errors++; $display("FAIL rst_pending: got %h want 0", pending_o); end
      checks++; if (fifo_empty_o !== 1'b1) begin errors++; $display("FAIL rst_empty: got %b want 1", fifo_empty_o); end
      checks++; if (we_b_o !== 1'b1 || waddr_b_o !== 5'd7) begin errors++; $display("FAIL rst_we_b_pinc: got %b/%0d want 1/7", we_b_o, waddr_b_o); end
      checks++; if (we_a_o !== 1'b1 || waddr_a_o !== 5'd2 || wdata_a_o !== 32'h1234) begin errors++; $display("FAIL rst_port_a: got %b/%0d/%h want 1/2/1234", we_a_o, waddr_a_o, wdata_a_o); end
      pinc_we_i = 0;
      #1;
      checks++; if (we_b_o !== 1'b0) begin errors++; $display("FAIL rst_we_b_idle: got %b want 0", we_b_o); end
      do_reset();
   endtask

   task automatic test_load_only();
      do_reset();
      push_load(5'd3, 32'hA5A5_A5A5);
      to_neg();
      checks++; if (we_b_o !== 1'b0) begin errors++; $display("FAIL lo_no_bypass: got %b want 0", we_b_o); end
      to_edge();
      idle_inputs();
      to_neg();
      checks++; if (we_b_o !== 1'b1 || waddr_b_o !== 5'd3 || wdata_b_o !== 32'hA5A5_A5A5) begin errors++; $display("FAIL lo_write: got %b/%0d/%h want 1/3/a5a5a5a5", we_b_o, waddr_b_o, wdata_b_o); end
      checks++; if (pending_o !== 32'h0000_0008) begin errors++; $display("FAIL lo_pending: got %h want 00000008", pending_o); end
      to_edge();
      to_neg();
      checks++; if (fifo_empty_o !== 1'b1 || pending_o !== '0 || we_b_o !== 1'b0) begin errors++; $display("FAIL lo_drained: got empty=%b pend=%h we_b=%b want 1/0/0", fifo_empty_o, pending_o, we_b_o); end
      to_edge();
   endtask

   task automatic test_contention();
      do_reset();
      for (int c = 0; c <= 10; c++) begin
         idle_inputs();
         if (c < 6) begin pinc_we_i = 1; pinc_waddr_i = 5'd20; pinc_wdata_i = 32'hDEAD_0000 + c; end
         if (c < 4) push_load(AW'(4 + c), 32'h100 + c);
         to_neg();
         if (c == 4) begin
            checks++; if (lsu_ready_o !== 1'b0) begin errors++; $display("FAIL ct_full: got %b want 0", lsu_ready_o); end
         end
         if (c < 6) begin
            checks++; if (we_b_o !== 1'b1 || waddr_b_o !== 5'd20) begin errors++; $display("FAIL ct_pinc c%0d: got %b/%0d want 1/20", c, we_b_o, waddr_b_o); end
         end else if (c < 10) begin
            checks++; if (we_b_o !== 1'b1 || waddr_b_o !== AW'(c - 2) || wdata_b_o !== 32'h100 + c - 6) begin errors++; $display("FAIL ct_drain c%0d: got %b/%0d/%h want 1/%0d/%h", c, we_b_o, waddr_b_o, wdata_b_o, c - 2, 32'h100 + c - 6); end
         end else begin
            checks++; if (fifo_empty_o !== 1'b1 || we_b_o !== 1'b0) begin errors++; $display("FAIL ct_empty: got %b/%b want 1/0", fifo_empty_o, we_b_o); end
         end
         to_edge();
      end
   endtask

   task automatic test_waw_kill();
      do_reset();
      foreach (rf[i]) rf[i] = '0;
      for (int c = 0; c <= 5; c++) begin
         idle_inputs();
         if (c < 3) begin pinc_we_i = 1; pinc_waddr_i = 5'd10; pinc_wdata_i = 32'h55; end
         if (c == 0) push_load(5'd12, 32'h33);
         if (c == 1) push_load(5'd5, 32'h11);
         if (c == 2) begin alu_we_i = 1; alu_waddr_i = 5'd5; alu_wdata_i = 32'h22; end
         to_neg();
         if (c == 2) begin
            checks++; if (pending_o[5] !== 1'b1 || pending_o[12] !== 1'b1) begin errors++; $display("FAIL waw_pend_before: got %h", pending_o); end
         end
         if (c == 3) begin
            checks++; if (pending_o[5] !== 1'b0 || pending_o[12] !== 1'b1 || fifo_empty_o !== 1'b0) begin errors++; $display("FAIL waw_pend_after: got %h empty=%b want r5=0 r12=1 empty=0", pending_o, fifo_empty_o); end
            checks++; if (we_b_o !== 1'b1 || waddr_b_o !== 5'd12 || wdata_b_o !== 32'h33) begin errors++; $display("FAIL waw_r12: got %b/%0d/%h want 1/12/33", we_b_o, waddr_b_o, wdata_b_o); end
         end
         if (c == 4) begin
            checks++; if (we_b_o !== 1'b0 || fifo_empty_o !== 1'b0) begin errors++; $display("FAIL waw_killed_head: got we_b=%b empty=%b want 0/0", we_b_o, fifo_empty_o); end
         end
         if (c == 5) begin
            checks++; if (fifo_empty_o !== 1'b1) begin errors++; $display("FAIL waw_empty: got %b want 1", fifo_empty_o); end
         end
         to_edge();
      end
      checks++; if (rf[5] !== 32'h22 || rf[12] !== 32'h33) begin errors++; $display("FAIL waw_final: got r5=%h r12=%h want 22/33", rf[5], rf[12]); end
   endtask

   task automatic test_same_cycle_hazard();
      do_reset();
      push_load(5'd9, 32'hCAFE);
      to_neg(); to_edge();
      idle_inputs();
      alu_we_i = 1; alu_waddr_i = 5'd9; alu_wdata_i = 32'h77;
      to_neg();
      checks++; if (we_b_o !== 1'b0 || we_a_o !== 1'b1 || fifo_empty_o !== 1'b0) begin errors++; $display("FAIL hz_same: got we_b=%b we_a=%b empty=%b want 0/1/0", we_b_o, we_a_o, fifo_empty_o); end
      to_edge();
      idle_inputs();
      to_neg();
      checks++; if (fifo_empty_o !== 1'b1 || pending_o !== '0 || we_b_o !== 1'b0) begin errors++; $display("FAIL hz_popped: got empty=%b pend=%h we_b=%b want 1/0/0", fifo_empty_o, pending_o, we_b_o); end
      to_edge();
   endtask

   // use_reset=0: flush_i clears the FIFO; use_reset=1: rst_n is pulled low in the middle of the drain.
   task automatic test_flush_or_reset(input bit use_reset);
      do_reset();
      for (int c = 0; c < 3; c++) begin
         idle_inputs();
         pinc_we_i = 1; pinc_waddr_i = 5'd30;
         push_load(AW'(c + 1), 32'hF0 + c);
         to_neg(); to_edge();
      end
      idle_inputs();
      if (use_reset) begin
         to_neg();
         checks++; if (we_b_o !== 1'b1 || waddr_b_o !== 5'd1) begin errors++; $display("FAIL rs_drain: got %b/%0d want 1/1", we_b_o, waddr_b_o); end
         to_edge();
         rst_n = 1'b0;
         mq.delete();
         #1;
         checks++; if (fifo_empty_o !== 1'b1 || we_b_o !== 1'b0 || pending_o !== '0 || lsu_ready_o !== 1'b1) begin errors++; $display("FAIL rs_async: got empty=%b we_b=%b pend=%h ready=%b", fifo_empty_o, we_b_o, pending_o, lsu_ready_o); end
         @(negedge clk);
         rst_n = 1'b1;
         @(posedge clk);
         #1;
      end else begin
         flush_i = 1;
         push_load(5'd7, 32'h99);
         to_neg();
         checks++; if (we_b_o !== 1'b0 || lsu_ready_o !== 1'b1) begin errors++; $display("FAIL fl_cycle: got we_b=%b ready=%b want 0/1", we_b_o, lsu_ready_o); end
         to_edge();
         idle_inputs();
      end
      for (int c = 0; c < 3; c++) begin
         to_neg();
         checks++; if (fifo_empty_o !== 1'b1 || we_b_o !== 1'b0 || pending_o !== '0) begin errors++; $display("FAIL fl_after%0d r%0d: got empty=%b we_b=%b pend=%h", use_reset, c, fifo_empty_o, we_b_o, pending_o); end
         to_edge();
      end
   endtask

   task automatic test_zero_reg();
      do_reset();
      alu_we_i = 1; alu_waddr_i = '0; alu_wdata_i = 32'h1;
      pinc_we_i = 1; pinc_waddr_i = '0; pinc_wdata_i = 32'h2;
      push_load('0, 32'h3);
      to_neg();
      checks++; if (we_a_o !== !ZERO || we_b_o !== !ZERO) begin errors++; $display("FAIL z_we: got %b/%b want %b/%b", we_a_o, we_b_o, !ZERO, !ZERO); end
      to_edge();
      idle_inputs();
      push_load('0, 32'h4);
      to_neg();
      checks++; if (fifo_empty_o !== ZERO || pending_o[0] !== 1'b0) begin errors++; $display("FAIL z_fifo: got empty=%b p0=%b want %b/0", fifo_empty_o, pending_o[0], ZERO); end
      to_edge();
      idle_inputs();
      to_neg();
      checks++; if (pending_o[0] !== !ZERO || we_b_o !== !ZERO) begin errors++; $display("FAIL z_load: got p0=%b we_b=%b want %b/%b", pending_o[0], we_b_o, !ZERO, !ZERO); end
      to_edge();
      repeat (2) begin to_neg(); to_edge(); end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 600; c++) begin
         alu_we_i     = ($urandom_range(0, 1) == 1);
         alu_waddr_i  = AW'($urandom_range(0, 7));
         alu_wdata_i  = $urandom;
         pinc_we_i    = ($urandom_range(0, 3) == 0);
         pinc_waddr_i = AW'($urandom_range(0, 7));
         pinc_wdata_i = $urandom;
         lsu_valid_i  = ($urandom_range(0, 9) < 6);
         lsu_waddr_i  = AW'($urandom_range(0, 7));
         lsu_wdata_i  = $urandom;
         flush_i      = ($urandom_range(0, 39) == 0);
         to_neg();
         checks++;
         if (we_a_o !== exp_we_a || waddr_a_o !== alu_waddr_i || wdata_a_o !== alu_wdata_i) begin
            errors++; $display("FAIL rnd_port_a c%0d: got %b/%0d/%h want %b/%0d/%h", c, we_a_o, waddr_a_o, wdata_a_o, exp_we_a, alu_waddr_i, alu_wdata_i);
         end
         checks++;
         if (we_b_o !== exp_we_b || (exp_we_b && (waddr_b_o !== exp_waddr_b || wdata_b_o !== exp_wdata_b))) begin
            errors++; $display("FAIL rnd_port_b c%0d: got %b/%0d/%h want %b/%0d/%h", c, we_b_o, waddr_b_o, wdata_b_o, exp_we_b, exp_waddr_b, exp_wdata_b);
         end
         checks++;
         if (pending_o !== exp_pending || fifo_empty_o !== exp_empty || lsu_ready_o !== exp_ready) begin
            errors++; $display("FAIL rnd_state c%0d: got pend=%h empty=%b ready=%b want %h/%b/%b", c, pending_o, fifo_empty_o, lsu_ready_o, exp_pending, exp_empty, exp_ready);
         end
         to_edge();
      end
   endtask

   initial begin
      rst_n = 1'b0;
      idle_inputs();
      test_reset();
      test_load_only();
      test_contention();
      test_waw_kill();
      test_same_cycle_hazard();
      test_flush_or_reset(1'b0);
      test_flush_or_reset(1'b1);
      test_zero_reg();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
